// File: rtl/etroc_tdc_pkg.sv
// etroc_tdc_pkg: shared default widths, field result types and the ones-count width helper
// for the ETROC TDC encoder.
package etroc_tdc_pkg;

    localparam int unsigned FINE_W_DEF     = 63;
    localparam int unsigned TOT_FINE_W_DEF = 31;
    localparam int unsigned CNT_W_DEF      = 3;
    localparam int unsigned CODE_W_DEF     = 10;
    localparam int unsigned TOT_CODE_W_DEF = 9;
    localparam int unsigned HIT_CNT_W      = 16;

    // Width needed to hold a popcount of 0..width.
    function automatic int unsigned ones_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

    typedef struct packed {
        logic [CODE_W_DEF-1:0] code;
        logic                  err;
    } tdc_field_t;

    typedef struct packed {
        logic [TOT_CODE_W_DEF-1:0] code;
        logic                      err;
    } tdc_tot_field_t;

endpackage

// File: rtl/etroc_tdc_field_enc.sv
// etroc_tdc_field_enc: one TDC field (TOA, TOT or Cal). S2 registers popcount and bubble flag,
// S3 registers the coarse-merged code and the field error flag.
module etroc_tdc_field_enc
    import etroc_tdc_pkg::*;
#(
    parameter int unsigned FINE_W = FINE_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned CODE_W = CODE_W_DEF
) (
    input  logic              clk40,
    input  logic              reset,
    input  logic              s1_valid,
    input  logic              s2_valid,
    input  logic [FINE_W-1:0] raw,
    input  logic [CNT_W-1:0]  cnt_a,
    input  logic [CNT_W-1:0]  cnt_b,
    input  logic              sel_raw,
    output logic [CODE_W-1:0] code_nxt,
    output logic              err_nxt,
    output logic [CODE_W-1:0] code,
    output logic              err
);

    localparam int unsigned       OW   = ones_w(FINE_W);
    localparam logic [OW-1:0]     HALF = OW'(FINE_W / 2);

    logic [OW-1:0]     ones_d, ones_q;
    logic              bubble_d, bubble_q;
    logic [CNT_W-1:0]  cnt_a_d, cnt_a_q;
    logic [CNT_W-1:0]  cnt_b_d, cnt_b_q;
    logic [CODE_W-1:0] code_d, code_q;
    logic              err_d, err_q;
    logic [CNT_W-1:0]  coarse;
    logic [CNT_W-1:0]  cnt_diff;

    // S2: popcount and bubble detection (a 1 directly above a 0).
    always_comb begin
        ones_d   = ones_q;
        bubble_d = bubble_q;
        cnt_a_d  = cnt_a_q;
        cnt_b_d  = cnt_b_q;
        if (s1_valid) begin
            ones_d = '0;
            for (int unsigned i = 0; i < FINE_W; i++) begin
                ones_d = ones_d + OW'(raw[i]);
            end
            bubble_d = |(raw[FINE_W-1:1] & ~raw[FINE_W-2:0]);
            cnt_a_d  = cnt_a;
            cnt_b_d  = cnt_b;
        end
    end

    // S3: short fine values pair with counter B, long ones with counter A.
    always_comb begin
        coarse   = (ones_q < HALF) ? cnt_b_q : cnt_a_q;
        cnt_diff = cnt_a_q - cnt_b_q;
        code_nxt = sel_raw ? CODE_W'(ones_q)
                           : CODE_W'(32'(coarse) * FINE_W + 32'(ones_q));
        err_nxt  = bubble_q || ((cnt_diff != '0) && (cnt_diff != CNT_W'(1)));
        code_d   = s2_valid ? code_nxt : code_q;
        err_d    = s2_valid ? err_nxt : err_q;
    end

    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            ones_q   <= '0;
            bubble_q <= 1'b0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            code_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            ones_q   <= ones_d;
            bubble_q <= bubble_d;
            cnt_a_q  <= cnt_a_d;
            cnt_b_q  <= cnt_b_d;
            code_q   <= code_d;
            err_q    <= err_d;
        end
    end

    assign code = code_q;
    assign err  = err_q;

endmodule

// File: rtl/etroc_tdc_encoder_p.sv
// etroc_tdc_encoder_p: 3-stage TDC code encoder (TOA/TOT/Cal) with TOA hit window and hit counter.
// Optional raw-word monitor outputs are built when ETROC_TDC_RAWMON_EN is defined.
module etroc_tdc_encoder_p
    import etroc_tdc_pkg::*;
#(
    parameter int unsigned FINE_W     = FINE_W_DEF,
    parameter int unsigned TOT_FINE_W = TOT_FINE_W_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned CODE_W     = CODE_W_DEF,
    parameter int unsigned TOT_CODE_W = TOT_CODE_W_DEF
) (
    input  logic                  clk40,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [FINE_W-1:0]     toa_raw,
    input  logic [FINE_W-1:0]     cal_raw,
    input  logic [TOT_FINE_W-1:0] tot_raw,
    input  logic [CNT_W-1:0]      toa_cnt_a,
    input  logic [CNT_W-1:0]      toa_cnt_b,
    input  logic [CNT_W-1:0]      tot_cnt_a,
    input  logic [CNT_W-1:0]      tot_cnt_b,
    input  logic [CNT_W-1:0]      cal_cnt_a,
    input  logic [CNT_W-1:0]      cal_cnt_b,
    input  logic                  sel_raw,
    input  logic [CODE_W-1:0]     win_lo,
    input  logic [CODE_W-1:0]     win_hi,
    input  logic                  clr_count,
`ifdef ETROC_TDC_RAWMON_EN
    input  logic                  enable_mon,
    output logic [FINE_W-1:0]     toa_raw_mon,
    output logic [FINE_W-1:0]     cal_raw_mon,
    output logic [TOT_FINE_W-1:0] tot_raw_mon,
`endif
    output logic                  out_valid,
    output logic [CODE_W-1:0]     toa_code,
    output logic [CODE_W-1:0]     cal_code,
    output logic [TOT_CODE_W-1:0] tot_code,
    output logic                  toa_err,
    output logic                  tot_err,
    output logic                  cal_err,
    output logic                  hit_flag,
    output logic [HIT_CNT_W-1:0]  hit_count
);

    typedef struct packed {
        logic [FINE_W-1:0]     toa;
        logic [FINE_W-1:0]     cal;
        logic [TOT_FINE_W-1:0] tot;
        logic [CNT_W-1:0]      toa_a;
        logic [CNT_W-1:0]      toa_b;
        logic [CNT_W-1:0]      tot_a;
        logic [CNT_W-1:0]      tot_b;
        logic [CNT_W-1:0]      cal_a;
        logic [CNT_W-1:0]      cal_b;
    } s1_t;

    s1_t                    s1_d, s1_q;
    logic                   s1_valid_d, s1_valid_q;
    logic                   s2_valid_d, s2_valid_q;
    logic                   out_valid_d, out_valid_q;
    logic                   hit_d, hit_q;
    logic [HIT_CNT_W-1:0]   hit_count_d, hit_count_q;
    logic [CODE_W-1:0]      toa_code_nxt;
    logic                   toa_err_nxt;
    logic [TOT_CODE_W-1:0]  tot_code_nxt_unused;
    logic                   tot_err_nxt_unused;
    logic [CODE_W-1:0]      cal_code_nxt_unused;
    logic                   cal_err_nxt_unused;

    // S1 capture and valid pipeline.
    always_comb begin
        s1_d = s1_q;
        if (in_valid) begin
            s1_d.toa   = toa_raw;
            s1_d.cal   = cal_raw;
            s1_d.tot   = tot_raw;
            s1_d.toa_a = toa_cnt_a;
            s1_d.toa_b = toa_cnt_b;
            s1_d.tot_a = tot_cnt_a;
            s1_d.tot_b = tot_cnt_b;
            s1_d.cal_a = cal_cnt_a;
            s1_d.cal_b = cal_cnt_b;
        end
        s1_valid_d  = in_valid;
        s2_valid_d  = s1_valid_q;
        out_valid_d = s2_valid_q;
    end

    etroc_tdc_field_enc #(.FINE_W(FINE_W), .CNT_W(CNT_W), .CODE_W(CODE_W)) u_toa (
        .clk40    (clk40),
        .reset    (reset),
        .s1_valid (s1_valid_q),
        .s2_valid (s2_valid_q),
        .raw      (s1_q.toa),
        .cnt_a    (s1_q.toa_a),
        .cnt_b    (s1_q.toa_b),
        .sel_raw  (sel_raw),
        .code_nxt (toa_code_nxt),
        .err_nxt  (toa_err_nxt),
        .code     (toa_code),
        .err      (toa_err)
    );

    etroc_tdc_field_enc #(.FINE_W(TOT_FINE_W), .CNT_W(CNT_W), .CODE_W(TOT_CODE_W)) u_tot (
        .clk40    (clk40),
        .reset    (reset),
        .s1_valid (s1_valid_q),
        .s2_valid (s2_valid_q),
        .raw      (s1_q.tot),
        .cnt_a    (s1_q.tot_a),
        .cnt_b    (s1_q.tot_b),
        .sel_raw  (sel_raw),
        .code_nxt (tot_code_nxt_unused),
        .err_nxt  (tot_err_nxt_unused),
        .code     (tot_code),
        .err      (tot_err)
    );

    etroc_tdc_field_enc #(.FINE_W(FINE_W), .CNT_W(CNT_W), .CODE_W(CODE_W)) u_cal (
        .clk40    (clk40),
        .reset    (reset),
        .s1_valid (s1_valid_q),
        .s2_valid (s2_valid_q),
        .raw      (s1_q.cal),
        .cnt_a    (s1_q.cal_a),
        .cnt_b    (s1_q.cal_b),
        .sel_raw  (sel_raw),
        .code_nxt (cal_code_nxt_unused),
        .err_nxt  (cal_err_nxt_unused),
        .code     (cal_code),
        .err      (cal_err)
    );

    // Window compare uses the S3 next-state TOA code so hit_flag lines up with out_valid.
    always_comb begin
        hit_d = s2_valid_q && !toa_err_nxt
                && (win_lo <= toa_code_nxt) && (toa_code_nxt <= win_hi);
        hit_count_d = hit_count_q;
        if (clr_count) begin
            hit_count_d = hit_d ? HIT_CNT_W'(1) : '0;
        end else if (hit_d && (hit_count_q != '1)) begin
            hit_count_d = hit_count_q + HIT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            s1_q        <= '0;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            hit_count_q <= '0;
        end else begin
            s1_q        <= s1_d;
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            out_valid_q <= out_valid_d;
            hit_q       <= hit_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign hit_flag  = hit_q;
    assign hit_count = hit_count_q;

`ifdef ETROC_TDC_RAWMON_EN
    logic [FINE_W-1:0]     toa_s2_d, toa_s2_q, toa_mon_d, toa_mon_q;
    logic [FINE_W-1:0]     cal_s2_d, cal_s2_q, cal_mon_d, cal_mon_q;
    logic [TOT_FINE_W-1:0] tot_s2_d, tot_s2_q, tot_mon_d, tot_mon_q;

    // Raw words trail the field pipeline by one stage so the monitor sees the S3 hit.
    always_comb begin
        toa_s2_d  = s1_valid_q ? s1_q.toa : toa_s2_q;
        cal_s2_d  = s1_valid_q ? s1_q.cal : cal_s2_q;
        tot_s2_d  = s1_valid_q ? s1_q.tot : tot_s2_q;
        toa_mon_d = toa_mon_q;
        cal_mon_d = cal_mon_q;
        tot_mon_d = tot_mon_q;
        if (s2_valid_q && enable_mon) begin
            toa_mon_d = toa_s2_q;
            cal_mon_d = cal_s2_q;
            tot_mon_d = tot_s2_q;
        end
    end

    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            toa_s2_q  <= '0;
            cal_s2_q  <= '0;
            tot_s2_q  <= '0;
            toa_mon_q <= '0;
            cal_mon_q <= '0;
            tot_mon_q <= '0;
        end else begin
            toa_s2_q  <= toa_s2_d;
            cal_s2_q  <= cal_s2_d;
            tot_s2_q  <= tot_s2_d;
            toa_mon_q <= toa_mon_d;
            cal_mon_q <= cal_mon_d;
            tot_mon_q <= tot_mon_d;
        end
    end

    assign toa_raw_mon = toa_mon_q;
    assign cal_raw_mon = cal_mon_q;
    assign tot_raw_mon = tot_mon_q;
`endif

endmodule

// File: tb/tb_etroc_tdc_encoder_p.sv
// tb_etroc_tdc_encoder_p: directed self-checking bench for etroc_tdc_encoder_p (default parameters).
module tb_etroc_tdc_encoder_p;

    logic        clk40 = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [62:0] toa_raw, cal_raw;
    logic [30:0] tot_raw;
    logic [2:0]  toa_cnt_a, toa_cnt_b, tot_cnt_a, tot_cnt_b, cal_cnt_a, cal_cnt_b;
    logic        sel_raw;
    logic [9:0]  win_lo, win_hi;
    logic        clr_count;
    logic        out_valid;
    logic [9:0]  toa_code, cal_code;
    logic [8:0]  tot_code;
    logic        toa_err, tot_err, cal_err, hit_flag;
    logic [15:0] hit_count;
`ifdef ETROC_TDC_RAWMON_EN
    logic [62:0] toa_raw_mon, cal_raw_mon;
    logic [30:0] tot_raw_mon;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_cnt   = 0;

    always #5 clk40 = ~clk40;

    etroc_tdc_encoder_p dut (
        .clk40       (clk40),
        .reset       (reset),
        .in_valid    (in_valid),
        .toa_raw     (toa_raw),
        .cal_raw     (cal_raw),
        .tot_raw     (tot_raw),
        .toa_cnt_a   (toa_cnt_a),
        .toa_cnt_b   (toa_cnt_b),
        .tot_cnt_a   (tot_cnt_a),
        .tot_cnt_b   (tot_cnt_b),
        .cal_cnt_a   (cal_cnt_a),
        .cal_cnt_b   (cal_cnt_b),
        .sel_raw     (sel_raw),
        .win_lo      (win_lo),
        .win_hi      (win_hi),
        .clr_count   (clr_count),
`ifdef ETROC_TDC_RAWMON_EN
        .enable_mon  (1'b1),
        .toa_raw_mon (toa_raw_mon),
        .cal_raw_mon (cal_raw_mon),
        .tot_raw_mon (tot_raw_mon),
`endif
        .out_valid   (out_valid),
        .toa_code    (toa_code),
        .cal_code    (cal_code),
        .tot_code    (tot_code),
        .toa_err     (toa_err),
        .tot_err     (tot_err),
        .cal_err     (cal_err),
        .hit_flag    (hit_flag),
        .hit_count   (hit_count)
    );

    function automatic logic [62:0] therm63(input int n);
        logic [63:0] t;
        t = (64'd1 << n) - 64'd1;
        return t[62:0];
    endfunction

    function automatic logic [30:0] therm31(input int n);
        logic [31:0] t;
        t = (32'd1 << n) - 32'd1;
        return t[30:0];
    endfunction

    task automatic set_toa(input logic [62:0] raw, input logic [2:0] a, input logic [2:0] b);
        toa_raw   = raw;
        toa_cnt_a = a;
        toa_cnt_b = b;
    endtask

    // Pulses in_valid for one cycle and returns the cycles until out_valid (-1 on timeout).
    task automatic send_wait(output int lat);
        in_valid = 1'b1;
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk40);
            #1;
            in_valid = 1'b0;
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; sel_raw = 1'b0; clr_count = 1'b0;
        win_lo = 10'd0; win_hi = 10'h3FF;
        set_toa('0, 3'd0, 3'd0);
        cal_raw = '0; cal_cnt_a = '0; cal_cnt_b = '0;
        tot_raw = '0; tot_cnt_a = '0; tot_cnt_b = '0;
        repeat (3) @(posedge clk40);
        #1;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else pass_cnt++;
        total_cnt++;
        if ({toa_code, tot_code, cal_code} !== 29'd0)
            $display("FAIL reset_codes got=%h exp=0", {toa_code, tot_code, cal_code});
        else pass_cnt++;
        total_cnt++;
        if ({toa_err, tot_err, cal_err, hit_flag} !== 4'd0)
            $display("FAIL reset_flags got=%b exp=0000", {toa_err, tot_err, cal_err, hit_flag});
        else pass_cnt++;
        total_cnt++;
        if (hit_count !== 16'd0) $display("FAIL reset_count got=%0d exp=0", hit_count); else pass_cnt++;
        reset = 1'b0;
        @(posedge clk40);
        #1;
    endtask

    task automatic test_basic();
        int lat;
        set_toa(therm63(20), 3'd3, 3'd3);
        tot_raw = therm31(10); tot_cnt_a = 3'd2; tot_cnt_b = 3'd2;
        cal_raw = therm63(63); cal_cnt_a = 3'd7; cal_cnt_b = 3'd7;
        send_wait(lat);
        exp_cnt++;
        total_cnt++;
        if (lat !== 3) $display("FAIL basic_latency got=%0d exp=3", lat); else pass_cnt++;
        total_cnt++;
        if (toa_code !== 10'd209) $display("FAIL basic_toa_code got=%0d exp=209", toa_code); else pass_cnt++;
        total_cnt++;
        if (tot_code !== 9'd72) $display("FAIL basic_tot_code got=%0d exp=72", tot_code); else pass_cnt++;
        total_cnt++;
        if (cal_code !== 10'd504) $display("FAIL basic_cal_code got=%0d exp=504", cal_code); else pass_cnt++;
        total_cnt++;
        if ({toa_err, tot_err, cal_err} !== 3'b000)
            $display("FAIL basic_errs got=%b exp=000", {toa_err, tot_err, cal_err});
        else pass_cnt++;
        total_cnt++;
        if (hit_flag !== 1'b1) $display("FAIL basic_hit got=%b exp=1", hit_flag); else pass_cnt++;
        total_cnt++;
        if (hit_count !== 16'(exp_cnt)) $display("FAIL basic_count got=%0d exp=%0d", hit_count, exp_cnt); else pass_cnt++;
        @(posedge clk40);
        #1;
        total_cnt++;
        if ({out_valid, hit_flag} !== 2'b00)
            $display("FAIL basic_pulse got=%b exp=00", {out_valid, hit_flag});
        else pass_cnt++;
        total_cnt++;
        if (toa_code !== 10'd209) $display("FAIL basic_hold got=%0d exp=209", toa_code); else pass_cnt++;
    endtask

    task automatic test_coarse_select();
        int        n    [7] = '{20 + 20, 40, 31, 30, 40, 0, 10};
        logic [2:0] a   [7] = '{3'd5, 3'd5, 3'd2, 3'd2, 3'd0, 3'd6, 3'd1};
        logic [2:0] b   [7] = '{3'd4, 3'd2, 3'd1, 3'd1, 3'd7, 3'd6, 3'd3};
        logic [9:0] code[7] = '{10'd355, 10'd355, 10'd157, 10'd93, 10'd40, 10'd378, 10'd199};
        logic       err [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 7; i++) begin
            set_toa(therm63(n[i]), a[i], b[i]);
            send_wait(lat);
            if (!err[i]) exp_cnt++;
            total_cnt++;
            if (lat !== 3) $display("FAIL coarse_latency[%0d] got=%0d exp=3", i, lat); else pass_cnt++;
            total_cnt++;
            if (toa_code !== code[i]) $display("FAIL coarse_code[%0d] got=%0d exp=%0d", i, toa_code, code[i]); else pass_cnt++;
            total_cnt++;
            if (toa_err !== err[i]) $display("FAIL coarse_err[%0d] got=%b exp=%b", i, toa_err, err[i]); else pass_cnt++;
            total_cnt++;
            if (hit_flag !== !err[i]) $display("FAIL coarse_hit[%0d] got=%b exp=%b", i, hit_flag, !err[i]); else pass_cnt++;
        end
        total_cnt++;
        if (hit_count !== 16'(exp_cnt)) $display("FAIL coarse_count got=%0d exp=%0d", hit_count, exp_cnt); else pass_cnt++;
    endtask

    task automatic test_bubble();
        int lat;
        set_toa(63'h0F0, 3'd1, 3'd1);
        send_wait(lat);
        total_cnt++;
        if ({toa_code, toa_err, hit_flag} !== {10'd67, 1'b1, 1'b0})
            $display("FAIL bubble_mid got=code %0d err %b hit %b exp=code 67 err 1 hit 0", toa_code, toa_err, hit_flag);
        else pass_cnt++;
        set_toa(63'h7FFF_FFFF_FFFF_FFFE, 3'd0, 3'd0);
        send_wait(lat);
        total_cnt++;
        if ({toa_code, toa_err, hit_flag} !== {10'd62, 1'b1, 1'b0})
            $display("FAIL bubble_low got=code %0d err %b hit %b exp=code 62 err 1 hit 0", toa_code, toa_err, hit_flag);
        else pass_cnt++;
        total_cnt++;
        if (hit_count !== 16'(exp_cnt)) $display("FAIL bubble_count got=%0d exp=%0d", hit_count, exp_cnt); else pass_cnt++;
    endtask

    task automatic test_sel_raw();
        int lat;
        sel_raw = 1'b1;
        set_toa(therm63(40), 3'd5, 3'd5);
        tot_raw = therm31(10); tot_cnt_a = 3'd2; tot_cnt_b = 3'd2;
        cal_raw = therm63(63); cal_cnt_a = 3'd7; cal_cnt_b = 3'd7;
        send_wait(lat);
        exp_cnt++;
        total_cnt++;
        if ({toa_code, tot_code, cal_code} !== {10'd40, 9'd10, 10'd63})
            $display("FAIL selraw_codes got=%0d/%0d/%0d exp=40/10/63", toa_code, tot_code, cal_code);
        else pass_cnt++;
        total_cnt++;
        if (hit_flag !== 1'b1) $display("FAIL selraw_hit got=%b exp=1", hit_flag); else pass_cnt++;
        sel_raw = 1'b0;
    endtask

    task automatic test_window_back_to_back();
        int         n     [4] = '{36, 37, 48, 49};
        logic [2:0] ab    [4] = '{3'd1, 3'd1, 3'd4, 3'd4};
        logic [9:0] code  [4] = '{10'd99, 10'd100, 10'd300, 10'd301};
        logic       hit   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [15:0] cnt  [4] = '{16'd0, 16'd1, 16'd2, 16'd2};
        int lat;
        clr_count = 1'b1;
        @(posedge clk40);
        #1;
        clr_count = 1'b0;
        exp_cnt = 0;
        total_cnt++;
        if (hit_count !== 16'd0) $display("FAIL clr_alone got=%0d exp=0", hit_count); else pass_cnt++;
        win_lo = 10'd100; win_hi = 10'd300;
        for (int k = 0; k < 7; k++) begin
            if (k >= 3) begin
                total_cnt++;
                if ({out_valid, toa_code, hit_flag, hit_count} !== {1'b1, code[k-3], hit[k-3], cnt[k-3]})
                    $display("FAIL window[%0d] got=valid %b code %0d hit %b cnt %0d exp=valid 1 code %0d hit %b cnt %0d",
                             k - 3, out_valid, toa_code, hit_flag, hit_count, code[k-3], hit[k-3], cnt[k-3]);
                else pass_cnt++;
            end
            if (k < 4) begin
                set_toa(therm63(n[k]), ab[k], ab[k]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk40);
            #1;
        end
        exp_cnt = 2;
        win_lo = 10'd300; win_hi = 10'd100;
        set_toa(therm63(20), 3'd3, 3'd3);
        send_wait(lat);
        total_cnt++;
        if ({toa_code, hit_flag, hit_count} !== {10'd209, 1'b0, 16'd2})
            $display("FAIL window_inverted got=code %0d hit %b cnt %0d exp=code 209 hit 0 cnt 2", toa_code, hit_flag, hit_count);
        else pass_cnt++;
        win_lo = 10'd0; win_hi = 10'h3FF;
    endtask

    task automatic test_saturation();
        int lat;
        clr_count = 1'b1;
        @(posedge clk40);
        #1;
        clr_count = 1'b0;
        set_toa(therm63(20), 3'd3, 3'd3);
        in_valid = 1'b1;
        repeat (65535) @(posedge clk40);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk40);
        #1;
        total_cnt++;
        if (hit_count !== 16'hFFFF) $display("FAIL sat_preload got=%h exp=ffff", hit_count); else pass_cnt++;
        send_wait(lat);
        total_cnt++;
        if ({lat == 3, hit_flag, hit_count} !== {1'b1, 1'b1, 16'hFFFF})
            $display("FAIL sat_hold got=lat %0d hit %b cnt %h exp=lat 3 hit 1 cnt ffff", lat, hit_flag, hit_count);
        else pass_cnt++;
        in_valid = 1'b1;
        @(posedge clk40);
        #1;
        in_valid = 1'b0;
        @(posedge clk40);
        #1;
        clr_count = 1'b1;
        @(posedge clk40);
        #1;
        clr_count = 1'b0;
        total_cnt++;
        if ({out_valid, hit_flag, hit_count} !== {1'b1, 1'b1, 16'd1})
            $display("FAIL clr_with_hit got=valid %b hit %b cnt %0d exp=valid 1 hit 1 cnt 1", out_valid, hit_flag, hit_count);
        else pass_cnt++;
    endtask

    task automatic test_midflight_reset();
        int  lat;
        logic seen;
        set_toa(therm63(20), 3'd3, 3'd3);
        in_valid = 1'b1;
        @(posedge clk40);
        #1;
        set_toa(therm63(40), 3'd5, 3'd4);
        @(posedge clk40);
        #1;
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({out_valid, toa_code, tot_code, cal_code, toa_err, tot_err, cal_err, hit_flag, hit_count} !== 50'd0)
            $display("FAIL midreset_outputs got=valid %b toa %0d tot %0d cal %0d hit %b cnt %0d exp=all 0",
                     out_valid, toa_code, tot_code, cal_code, hit_flag, hit_count);
        else pass_cnt++;
        @(posedge clk40);
        #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk40);
            #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL midreset_dropped got=valid seen exp=none"); else pass_cnt++;
        set_toa(therm63(40), 3'd5, 3'd5);
        send_wait(lat);
        total_cnt++;
        if (lat !== 3) $display("FAIL midreset_latency got=%0d exp=3", lat); else pass_cnt++;
        total_cnt++;
        if ({toa_code, hit_count} !== {10'd355, 16'd1})
            $display("FAIL midreset_first got=code %0d cnt %0d exp=code 355 cnt 1", toa_code, hit_count);
        else pass_cnt++;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_coarse_select();
        test_bubble();
        test_sel_raw();
        test_window_back_to_back();
        test_saturation();
        test_midflight_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/etroc_tdc_encoder_p.md
# etroc_tdc_encoder_p

Parametrised, pipelined TDC code encoder for the next-generation pixel TDC. It takes one raw delay-line snapshot per hit: TOA, TOT and Cal thermometer words plus two coarse ripple-counter samples each. It bubble-checks and counts each fine word, merges it with the selected coarse counter, and applies a TOA window to produce a hit flag. It sits between the TDC delay-line capture and the pixel readout buffer on the 40 MHz domain.

## Interface
- `FINE_W`, 63, TOA/Cal thermometer width
- `TOT_FINE_W`, 31, TOT thermometer width
- `CNT_W`, 3, coarse counter width
- `CODE_W`, 10, TOA/Cal code width
- `TOT_CODE_W`, 9, TOT code width
- `clk40`  in  1  single clock; all logic rising-edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `in_valid`  in  1  raw snapshot strobe, one hit per cycle max
- `toa_raw`, `cal_raw`  in  FINE_W  thermometer snapshots
- `tot_raw`  in  TOT_FINE_W  thermometer snapshot
- `toa_cnt_a`, `toa_cnt_b`, `tot_cnt_a`, `tot_cnt_b`, `cal_cnt_a`, `cal_cnt_b`  in  CNT_W  coarse counter samples
- `sel_raw`  in  1  static; when 1, codes equal the fine ones-count only
- `win_lo`, `win_hi`  in  CODE_W  static TOA hit window, inclusive
- `clr_count`  in  1  synchronous clear of hit counter
- `out_valid`  out  1  codes valid, one-cycle pulse
- `toa_code`, `cal_code`  out  CODE_W
- `tot_code`  out  TOT_CODE_W
- `toa_err`, `tot_err`, `cal_err`  out  1  per-field error flags
- `hit_flag`  out  1  qualified hit
- `hit_count`  out  16  saturating qualified-hit count

## Operation
- Fine value `ones` is the popcount of the raw word. Its width is clog2(width+1).
- Bubble error: the raw word is not of the form 0…01…1, i.e. some bit i is 1 while bit i-1 is 0.
- Coarse select: if `ones` < width/2 (integer division), use counter B; otherwise use A.
- Counter error: (A − B) mod 2^CNT_W is not 0 and not 1.
- Field error = bubble error OR counter error.
- Code = coarse_sel × width + `ones`, truncated to the code width. When `sel_raw`=1, code = `ones` zero-extended.
- Codes are output even when the error flag is set.
- `hit_flag` = `out_valid` AND `toa_err`=0 AND `win_lo` ≤ `toa_code` ≤ `win_hi`.
  - If `win_lo` > `win_hi`, `hit_flag` is never set.
- `hit_count` increments on every `hit_flag` cycle and saturates at 0xFFFF.
  - `clr_count` alone sets it to 0.
  - `clr_count` coincident with `hit_flag` sets it to 1.

## Timing
- 3-stage pipeline; no backpressure; throughput of one hit per cycle.
  - S1: register raw inputs.
  - S2: compute popcounts and bubble flags, register together with the counters.
  - S3: coarse select, counter check, code arithmetic, window compare; register outputs.
- Latency: `in_valid` at edge N gives `out_valid` at edge N+3.
- Code, error and hit outputs hold their last values while `out_valid`=0.
- Reset value of every output is 0, including `hit_count`.
- Reset mid-pipeline drops in-flight hits; no `out_valid` follows for them.
- The first hit accepted after reset deasserts takes full latency.
- `sel_raw`, `win_lo` and `win_hi` are sampled at S3. Changing them mid-flight affects only hits that are in S3 or later stages.

## Configuration
- `ETROC_TDC_RAWMON_EN` defined:
  - adds input `enable_mon`, plus outputs `toa_raw_mon`, `cal_raw_mon` (FINE_W) and `tot_raw_mon` (TOT_FINE_W);
  - these capture the S3-aligned raw words when `out_valid` AND `enable_mon`, and hold otherwise;
  - reset value is 0.
- Not defined: these ports and registers are absent. Encoder behaviour is identical either way.

## Structure
- Package `etroc_tdc_pkg` holds:
  - a `clog2`-based ones-width function;
  - a `tdc_field_t` struct (code, err) with TOA/Cal and TOT variants;
  - default parameter constants.
- One sub-module, `etroc_tdc_field_enc`, parametrised by fine width, CNT_W and code width. It implements popcount, bubble check, coarse select and code merge with its S2/S3 registers. It is instantiated 3× (TOA, TOT, Cal).

## Test plan
- TOA raw = 20 ones, cnt A=3, B=3, defaults → `out_valid` 3 cycles later; `toa_code`=3×63+20=209; `toa_err`=0.
- TOA raw = 40 ones, A=5, B=4 → selects A; code=5×63+40=355; `toa_err`=0.
  - A=5, B=2 → `toa_err`=1, code still 355.
- TOA raw = 0x…0F0 (bubble) → `toa_err`=1, `hit_flag`=0, even when the code lies inside the window.
- Window 100..300 with TOA codes 99, 100, 300, 301 back-to-back → `hit_flag` sequence 0,1,1,0; `hit_count`=2.
- 0xFFFF hits preload the counter, then a further hit → `hit_count` stays 0xFFFF.
  - `clr_count` together with a hit → `hit_count`=1.
- Assert `reset` while 2 hits are in flight → no `out_valid`, all outputs 0.
  - A new hit after release → valid after exactly 3 cycles.
